// File: rtl/iq_sweep_controller.sv
// Frequency-sweep sequencer for the IQ demodulator: steps the NCO increment, settles, averages I/Q.
// Optional build macro IQ_SWEEP_MAG_EN adds a registered |I|+|Q| estimate on res_mag.
module iq_sweep_controller #(
  parameter int PHASE_W  = 32,
  parameter int DATA_W   = 14,
  parameter int AVG_LOG2 = 8,
  parameter int SETTLE_W = 20,
  parameter int STEP_W   = 12
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic        [PHASE_W-1:0]  start_inc,
  input  logic        [PHASE_W-1:0]  step_inc,
  input  logic        [STEP_W-1:0]   num_steps,
  input  logic        [SETTLE_W-1:0] settle_cycles,
  output logic        [PHASE_W-1:0]  phaseInc,
  input  logic signed [DATA_W-1:0]   I_in,
  input  logic signed [DATA_W-1:0]   Q_in,
  input  logic        [1:0]          filtValid,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [DATA_W-1:0]   res_I,
  output logic signed [DATA_W-1:0]   res_Q,
  output logic        [STEP_W-1:0]   res_step,
  output logic        [DATA_W:0]     res_mag,
  output logic                       busy,
  output logic                       done
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_ACCUM,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  logic        [PHASE_W-1:0]  phase_q, phase_d;
  logic        [PHASE_W-1:0]  step_inc_q, step_inc_d;
  logic        [STEP_W-1:0]   num_steps_q, num_steps_d;
  logic        [SETTLE_W-1:0] settle_cfg_q, settle_cfg_d;
  logic        [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic        [STEP_W-1:0]   step_idx_q, step_idx_d;
  logic signed [ACC_W-1:0]    acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]    acc_q_q, acc_q_d;
  logic        [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic signed [DATA_W-1:0]   res_i_q, res_i_d;
  logic signed [DATA_W-1:0]   res_q_q, res_q_d;
  logic        [STEP_W-1:0]   res_step_q, res_step_d;
  logic                       res_valid_q, res_valid_d;
  logic                       done_q, done_d;

  logic signed [ACC_W-1:0]    acc_i_sum, acc_q_sum;
  logic signed [ACC_W-1:0]    avg_i, avg_q;
  logic                       sample_ok;

  assign sample_ok = (filtValid == 2'b11);
  assign acc_i_sum = acc_i_q + {{AVG_LOG2{I_in[DATA_W-1]}}, I_in};
  assign acc_q_sum = acc_q_q + {{AVG_LOG2{Q_in[DATA_W-1]}}, Q_in};
  // Arithmetic shift floors toward -inf; the sum of 2^AVG_LOG2 samples always fits DATA_W after it.
  assign avg_i     = acc_i_sum >>> AVG_LOG2;
  assign avg_q     = acc_q_sum >>> AVG_LOG2;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    step_inc_d   = step_inc_q;
    num_steps_d  = num_steps_q;
    settle_cfg_d = settle_cfg_q;
    settle_cnt_d = settle_cnt_q;
    step_idx_d   = step_idx_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    cnt_d        = cnt_q;
    res_i_d      = res_i_q;
    res_q_d      = res_q_q;
    res_step_d   = res_step_q;
    res_valid_d  = res_valid_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          step_inc_d   = step_inc;
          num_steps_d  = (num_steps == '0) ? STEP_W'(1) : num_steps;
          settle_cfg_d = settle_cycles;
          phase_d      = start_inc;
          step_idx_d   = '0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_i_d      = '0;
        acc_q_d      = '0;
        cnt_d        = '0;
        settle_cnt_d = settle_cfg_q;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_ACCUM;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      S_ACCUM: begin
        if (sample_ok) begin
          acc_i_d = acc_i_sum;
          acc_q_d = acc_q_sum;
          cnt_d   = cnt_q + AVG_LOG2'(1);
          if (&cnt_q) begin
            res_i_d     = avg_i[DATA_W-1:0];
            res_q_d     = avg_q[DATA_W-1:0];
            res_step_d  = step_idx_q;
            res_valid_d = 1'b1;
            state_d     = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (step_idx_q == num_steps_q - STEP_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            phase_d    = phase_q + step_inc_q;
            step_idx_d = step_idx_q + STEP_W'(1);
            state_d    = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a handshake landing in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      done_d      = 1'b1;
      phase_d     = phase_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      step_inc_q   <= '0;
      num_steps_q  <= '0;
      settle_cfg_q <= '0;
      settle_cnt_q <= '0;
      step_idx_q   <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      cnt_q        <= '0;
      res_i_q      <= '0;
      res_q_q      <= '0;
      res_step_q   <= '0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      step_inc_q   <= step_inc_d;
      num_steps_q  <= num_steps_d;
      settle_cfg_q <= settle_cfg_d;
      settle_cnt_q <= settle_cnt_d;
      step_idx_q   <= step_idx_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      cnt_q        <= cnt_d;
      res_i_q      <= res_i_d;
      res_q_q      <= res_q_d;
      res_step_q   <= res_step_d;
      res_valid_q  <= res_valid_d;
      done_q       <= done_d;
    end
  end

`ifdef IQ_SWEEP_MAG_EN
  logic signed [DATA_W:0] ext_i, ext_q;
  logic        [DATA_W:0] abs_i, abs_q;
  logic        [DATA_W:0] res_mag_q;

  // One extra bit so that the most negative sample has a representable magnitude.
  assign ext_i = {res_i_d[DATA_W-1], res_i_d};
  assign ext_q = {res_q_d[DATA_W-1], res_q_d};
  assign abs_i = ext_i[DATA_W] ? -ext_i : ext_i;
  assign abs_q = ext_q[DATA_W] ? -ext_q : ext_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      res_mag_q <= '0;
    end else begin
      res_mag_q <= abs_i + abs_q;
    end
  end

  assign res_mag = res_mag_q;
`else
  assign res_mag = '0;
`endif

  assign phaseInc  = phase_q;
  assign res_valid = res_valid_q;
  assign res_I     = res_i_q;
  assign res_Q     = res_q_q;
  assign res_step  = res_step_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: doc/iq_sweep_controller.md
Name: iq_sweep_controller

Overview:
Sequences a frequency sweep of the IQ demodulator datapath. For each step it drives the NCO phase-increment word and waits a programmable settling time for the mixer/FIR pipeline to flush. It then averages 2^AVG_LOG2 valid filtered I/Q samples and hands the averaged I, Q and step index to a downstream consumer over a valid/ready handshake. Sits between the user/control logic (start, frequency plan) and the IQ demodulator's phaseInc input and I/Q/filtValid outputs.

Parameters:
PHASE_W, 32, width of phase-increment word (NCO accumulator width)
DATA_W, 14, width of signed I/Q samples from the demodulator
AVG_LOG2, 8, log2 of number of samples averaged per step (1..12)
SETTLE_W, 20, width of settle-cycle counter
STEP_W, 12, width of step count/index

Ports:
CLK  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins sweep when IDLE, ignored otherwise
abort  input  1  level/pulse; terminates sweep at next edge
start_inc  input  PHASE_W  phase increment of step 0, sampled on start
step_inc  input  PHASE_W  phase increment added per step, sampled on start
num_steps  input  STEP_W  number of steps, sampled on start; 0 is treated as 1
settle_cycles  input  SETTLE_W  CLK cycles to wait after each increment change, sampled on start
phaseInc  output  PHASE_W  phase increment to NCO
I_in  input  DATA_W signed  filtered in-phase sample
Q_in  input  DATA_W signed  filtered quadrature sample
filtValid  input  2  per-channel filter valid; a sample counts only when both bits are 1
res_valid  output  1  averaged result available
res_ready  input  1  consumer accepts result
res_I  output  DATA_W signed  averaged I
res_Q  output  DATA_W signed  averaged Q
res_step  output  STEP_W  step index of result
res_mag  output  DATA_W+1  |I|+|Q| magnitude estimate (see Optional Feature)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the last result is accepted or after abort

Behaviour:
- Reset: state IDLE; phaseInc=0; res_valid=0; res_I=res_Q=0; res_step=0; res_mag=0; busy=0; done=0; accumulators and counters cleared.
- States: IDLE, LOAD, SETTLE, ACCUM, REPORT.
- IDLE: on start, latch the configuration inputs; phaseInc<=start_inc; step_idx<=0; go to LOAD.
- LOAD: clear the accumulators and sample counter; load settle counter=settle_cycles; go to SETTLE. Lasts 1 cycle.
- SETTLE: decrement the counter each cycle; filtValid is ignored. When counter==0, go to ACCUM. settle_cycles=0 gives exactly one SETTLE cycle.
- ACCUM: on each cycle with filtValid==2'b11, add sign-extended I_in/Q_in to accumulators of width DATA_W+AVG_LOG2 and increment the sample count. The cycle that adds sample 2^AVG_LOG2 registers res_I/res_Q = accum >>> AVG_LOG2 (arithmetic, truncation toward -inf) and res_step=step_idx, sets res_valid=1 and moves to REPORT. Cycles with partial filtValid (01/10) add nothing.
- REPORT: hold res_* stable while res_valid=1 and res_ready=0. On res_valid&&res_ready:
  - clear res_valid;
  - if step_idx==num_steps-1, pulse done and go to IDLE (phaseInc keeps its last value);
  - else phaseInc<=phaseInc+step_inc (mod 2^PHASE_W, wrap-around permitted), step_idx++, go to LOAD.
- res_ready high outside REPORT has no effect. Result latency per step = 1 + (settle_cycles+1) + valid-sample cycles.
- abort in any non-IDLE state: next edge goes to IDLE, res_valid<=0, done pulses 1 cycle, phaseInc holds. An abort in the same cycle as a REPORT handshake takes priority: the handshake completes, no next step is started, done pulses once.
- start while busy is ignored. start and abort together in IDLE: abort wins and the sweep does not start.
- reset asserted mid-sweep returns all outputs to their reset values on the next edge.

Optional Feature:
Macro IQ_SWEEP_MAG_EN. When defined, res_mag = |res_I| + |res_Q| (unsigned, DATA_W+1 bits), registered in the same cycle as res_I/res_Q, with -2^(DATA_W-1) magnitude = 2^(DATA_W-1). When undefined, res_mag is constant 0 and no abs/add logic is built.

Test Plan:
- Basic step: start_inc=0x0100_0000, num_steps=1, settle=4, AVG_LOG2=2, I_in=100, Q_in=-50, filtValid=11 constant -> res_valid exactly 1+5+4 cycles after LOAD entry, res_I=100, res_Q=-50, res_step=0; done pulses on the handshake.
- Sweep/wrap: start_inc=0xFFFF_FF00, step_inc=0x200, num_steps=3 -> phaseInc sequence 0xFFFF_FF00, 0x0000_0100, 0x0000_0300; res_step 0,1,2.
- Backpressure and gaps: res_ready low 10 cycles -> res_* stable; filtValid pattern 11,01,10,11 counts 2 samples; I samples 3,-4 with AVG_LOG2=1 -> res_I=-1 (floor).
- Abort: abort during SETTLE of step 1 -> IDLE next cycle, res_valid=0, done single pulse, busy=0; abort with start in IDLE -> no sweep starts.
- Reset mid-ACCUM, then new start -> accumulators clear, first result is uncorrupted by pre-reset samples.
- IQ_SWEEP_MAG_EN defined: res_I=-8192, res_Q=5 -> res_mag=8197; undefined -> res_mag=0.
